// File: rtl/alu_share_arb_if.sv
// Request/response bundle between two requesters and alu_share_arb.
// Requester i uses slice [i*WIDTH +: WIDTH] of req_a/req_b and [i*OPW +: OPW] of req_op.
// Optional feature macro: ALU_OVF_EN adds rsp_ovf to the response channel.
interface alu_share_arb_if #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
);
   logic [1:0]         req_valid;
   logic [1:0]         req_ready;
   logic [2*WIDTH-1:0] req_a;
   logic [2*WIDTH-1:0] req_b;
   logic [2*OPW-1:0]   req_op;
   logic [1:0]         rsp_valid;
   logic [1:0]         rsp_ready;
   logic [WIDTH-1:0]   rsp_y;
   logic               rsp_zero;
`ifdef ALU_OVF_EN
   logic               rsp_ovf;
`endif

`ifdef ALU_OVF_EN
   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_y, rsp_zero, rsp_ovf
   );
   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_y, rsp_zero, rsp_ovf
   );
`else
   modport master (
      output req_valid, req_a, req_b, req_op, rsp_ready,
      input  req_ready, rsp_valid, rsp_y, rsp_zero
   );
   modport slave (
      input  req_valid, req_a, req_b, req_op, rsp_ready,
      output req_ready, rsp_valid, rsp_y, rsp_zero
   );
`endif
endinterface

// File: rtl/alu_share_arb.sv
// Round-robin sharing of one external combinational ALU between two requesters.
// One operation in flight: operands are registered toward the ALU, the result is
// captured one cycle later and returned to the owning requester with a zero flag.
// Optional feature macro: ALU_OVF_EN adds a signed-overflow flag to the response.
//
// state | meaning
// IDLE  | waiting for a request; req_ready granted combinationally
// EXEC  | alu_* stable, ALU result captured at the end of this cycle
// RESP  | response held until rsp_ready[owner]
module alu_share_arb #(
   parameter int WIDTH = 32,
   parameter int OPW   = 3
) (
   input  logic              clk,
   input  logic              rst,
   alu_share_arb_if.slave    bus,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic [OPW-1:0]    alu_op,
   input  logic [WIDTH-1:0]  alu_y,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic             prio_q, prio_d;
   logic             owner_q, owner_d;
   logic [WIDTH-1:0] alu_a_q, alu_a_d;
   logic [WIDTH-1:0] alu_b_q, alu_b_d;
   logic [OPW-1:0]   alu_op_q, alu_op_d;
   logic [1:0]       rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0] rsp_y_q, rsp_y_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             busy_q, busy_d;
   logic [1:0]       grant;
   logic             sel;
`ifdef ALU_OVF_EN
   logic             rsp_ovf_q, rsp_ovf_d;
   logic             ovf_calc;
   logic             a_msb, b_msb, y_msb;
`endif

   // Grant the sole valid requester; on a tie the priority pointer decides.
   always_comb begin
      grant = 2'b00;
      if (state_q == IDLE) begin
         unique case (bus.req_valid)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = prio_q ? 2'b10 : 2'b01;
            default: grant = 2'b00;
         endcase
      end
   end

   assign sel = grant[1];

`ifdef ALU_OVF_EN
   // Signed overflow of the add/sub. For slt the ALU returns the sum msb in bit 0.
   always_comb begin
      a_msb    = alu_a_q[WIDTH-1];
      b_msb    = alu_b_q[WIDTH-1];
      y_msb    = (alu_op_q[1:0] == 2'b11) ? alu_y[0] : alu_y[WIDTH-1];
      ovf_calc = 1'b0;
      unique case (alu_op_q[2:1])
         2'b01:   ovf_calc = (a_msb & b_msb & ~y_msb) | (~a_msb & ~b_msb & y_msb);
         2'b11:   ovf_calc = (~a_msb & b_msb & y_msb) | (a_msb & ~b_msb & ~y_msb);
         default: ovf_calc = 1'b0;
      endcase
   end
`endif

   // Next-state and next-output computation for the sequencing FSM.
   always_comb begin
      state_d     = state_q;
      prio_d      = prio_q;
      owner_d     = owner_q;
      alu_a_d     = alu_a_q;
      alu_b_d     = alu_b_q;
      alu_op_d    = alu_op_q;
      rsp_valid_d = rsp_valid_q;
      rsp_y_d     = rsp_y_q;
      rsp_zero_d  = rsp_zero_q;
      busy_d      = busy_q;
`ifdef ALU_OVF_EN
      rsp_ovf_d   = rsp_ovf_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (grant != 2'b00) begin
               alu_a_d  = sel ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
               alu_b_d  = sel ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
               alu_op_d = sel ? bus.req_op[2*OPW-1:OPW]    : bus.req_op[OPW-1:0];
               owner_d  = sel;
               prio_d   = ~sel;
               state_d  = EXEC;
               busy_d   = 1'b1;
            end
         end
         EXEC: begin
            rsp_y_d     = alu_y;
            rsp_zero_d  = (alu_y == '0);
            rsp_valid_d = owner_q ? 2'b10 : 2'b01;
`ifdef ALU_OVF_EN
            rsp_ovf_d   = ovf_calc;
`endif
            state_d     = RESP;
         end
         RESP: begin
            if (bus.rsp_ready[owner_q]) begin
               rsp_valid_d = 2'b00;
               state_d     = IDLE;
               busy_d      = 1'b0;
            end
         end
         default: begin
            rsp_valid_d = 2'b00;
            state_d     = IDLE;
            busy_d      = 1'b0;
         end
      endcase
   end

   // Single state register for the FSM and all of its registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         prio_q      <= 1'b0;
         owner_q     <= 1'b0;
         alu_a_q     <= '0;
         alu_b_q     <= '0;
         alu_op_q    <= '0;
         rsp_valid_q <= 2'b00;
         rsp_y_q     <= '0;
         rsp_zero_q  <= 1'b0;
         busy_q      <= 1'b0;
`ifdef ALU_OVF_EN
         rsp_ovf_q   <= 1'b0;
`endif
      end else begin
         state_q     <= state_d;
         prio_q      <= prio_d;
         owner_q     <= owner_d;
         alu_a_q     <= alu_a_d;
         alu_b_q     <= alu_b_d;
         alu_op_q    <= alu_op_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_y_q     <= rsp_y_d;
         rsp_zero_q  <= rsp_zero_d;
         busy_q      <= busy_d;
`ifdef ALU_OVF_EN
         rsp_ovf_q   <= rsp_ovf_d;
`endif
      end
   end

   assign bus.req_ready = grant;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_y     = rsp_y_q;
   assign bus.rsp_zero  = rsp_zero_q;
`ifdef ALU_OVF_EN
   assign bus.rsp_ovf   = rsp_ovf_q;
`endif
   assign alu_a         = alu_a_q;
   assign alu_b         = alu_b_q;
   assign alu_op        = alu_op_q;
   assign busy          = busy_q;

endmodule
